// File: rtl/bit_timer.sv
// bit_timer: times N bit periods of P clocks, strobing mid-bit and pulsing done after the last bit
module bit_timer #(
  parameter int CNT_BITS     = 4,
  parameter int BIT_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    enable_timer,
  input  logic                    abort,
  input  logic [CNT_BITS-1:0]     clks_per_bit,
  input  logic [BIT_CNT_BITS-1:0] num_bits,
  output logic                    shift_strobe,
  output logic [BIT_CNT_BITS-1:0] bit_index,
  output logic                    busy,
  output logic                    packet_done
);
  typedef enum logic [1:0] {IDLE, HALF, RUN, DONE} state_t;
  localparam logic [CNT_BITS-1:0]     C1 = 1;
  localparam logic [CNT_BITS-1:0]     C2 = 2;
  localparam logic [BIT_CNT_BITS-1:0] B1 = 1;
  state_t                  state_q;
  logic [CNT_BITS-1:0]     cnt_q, p_q, h_q, p_d;
  logic [BIT_CNT_BITS-1:0] n_q, n_d, idx_inc;
  assign p_d     = (clks_per_bit < C2) ? C2 : clks_per_bit;
  assign n_d     = (num_bits == '0) ? B1 : num_bits;
  assign idx_inc = bit_index + B1;
  // packet sequencer: half-bit lead-in, then full bit periods, then a single done cycle
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      p_q          <= '0;
      h_q          <= '0;
      n_q          <= '0;
      bit_index    <= '0;
      busy         <= 1'b0;
      shift_strobe <= 1'b0;
      packet_done  <= 1'b0;
    end else begin
      shift_strobe <= 1'b0;
      packet_done  <= 1'b0;
      if (abort) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        bit_index <= '0;
        busy      <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: if (enable_timer) begin
            state_q   <= HALF;
            cnt_q     <= C1;
            p_q       <= p_d;
            h_q       <= p_d >> 1;
            n_q       <= n_d;
            bit_index <= '0;
            busy      <= 1'b1;
          end
          HALF: if (cnt_q == h_q) begin
            shift_strobe <= 1'b1;
            cnt_q        <= C1;
            state_q      <= (n_q == B1) ? DONE : RUN;
          end else begin
            cnt_q <= cnt_q + C1;
          end
          RUN: if (cnt_q == p_q) begin
            shift_strobe <= 1'b1;
            cnt_q        <= C1;
            bit_index    <= idx_inc;
            state_q      <= (idx_inc == n_q - B1) ? DONE : RUN;
          end else begin
            cnt_q <= cnt_q + C1;
          end
          DONE: begin
            packet_done <= 1'b1;
            busy        <= 1'b0;
            bit_index   <= '0;
            cnt_q       <= '0;
            state_q     <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_bit_timer.sv
// tb_bit_timer: directed checks of strobe/done/busy/index timing, clamping, abort and async reset
module tb_bit_timer;
  logic       clk = 1'b0, n_rst = 1'b1, enable_timer = 1'b0, abort = 1'b0;
  logic [3:0] clks_per_bit = '0, num_bits = '0;
  logic       shift_strobe, busy, packet_done;
  logic [3:0] bit_index;
  int         n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  bit_timer #(.CNT_BITS(4), .BIT_CNT_BITS(4)) dut (
    .clk(clk), .n_rst(n_rst), .enable_timer(enable_timer), .abort(abort),
    .clks_per_bit(clks_per_bit), .num_bits(num_bits),
    .shift_strobe(shift_strobe), .bit_index(bit_index), .busy(busy), .packet_done(packet_done)
  );

  // expected {strobe, done, busy, index} at edge e of a packet with effective P, N
  function automatic logic [6:0] model(int p, int n, int e);
    int h, last;
    logic s, d, b;
    logic [3:0] idx;
    h    = p / 2;
    last = h + (n - 1) * p;
    s    = (e >= h) && (e <= last) && ((e - h) % p == 0);
    d    = (e == last + 1);
    b    = (e >= 0) && (e <= last);
    idx  = ((e >= h) && (e <= last)) ? 4'((e - h) / p) : 4'd0;
    return {s, d, b, idx};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [6:0] exp);
    logic [6:0] obs;
    obs = {shift_strobe, packet_done, busy, bit_index};
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic start(int p, int n);
    clks_per_bit = 4'(p);
    num_bits     = 4'(n);
    enable_timer = 1'b1;
    tick();
    enable_timer = 1'b0;
  endtask

  task automatic run(string tag, int p, int n, int from_e, int to_e);
    for (int e = from_e; e <= to_e; e++) begin
      chk($sformatf("%s e%0d", tag, e), model(p, n, e));
      if (e < to_e) tick();
    end
  endtask

  initial begin
    #1 n_rst = 1'b0;
    #2 chk("reset async", 7'd0);
    #8 chk("reset held", 7'd0);
    #1 n_rst = 1'b1;
    tick();
    chk("idle after reset", 7'd0);
    // nominal packet
    start(10, 8);
    run("t1", 10, 8, 0, 80);
    // single bit, then clamped period and count
    tick();
    start(4, 1);
    run("t2a", 4, 1, 0, 4);
    start(1, 0);
    run("t2b", 2, 1, 0, 3);
    // abort mid-packet, then restart
    start(10, 8);
    run("t3", 10, 8, 0, 19);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t3 abort e20", 7'd0);
    tick();
    chk("t3 e21", 7'd0);
    enable_timer = 1'b1;
    tick();
    enable_timer = 1'b0;
    run("t3r", 10, 8, 0, 80);
    // abort together with start stays idle
    enable_timer = 1'b1;
    abort = 1'b1;
    tick();
    enable_timer = 1'b0;
    abort = 1'b0;
    chk("t3 abort+start", 7'd0);
    tick();
    chk("t3 still idle", 7'd0);
    // abort in the cycle done would fire
    start(2, 1);
    run("t3d", 2, 1, 0, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t3 done suppressed", 7'd0);
    tick();
    chk("t3 idle after", 7'd0);
    // inputs changed mid-packet and restart attempt ignored
    start(6, 4);
    clks_per_bit = 4'd15;
    num_bits     = 4'd2;
    run("t4", 6, 4, 0, 7);
    enable_timer = 1'b1;
    tick();
    enable_timer = 1'b0;
    chk("t4 e8", model(6, 4, 8));
    tick();
    run("t4", 6, 4, 9, 21);
    enable_timer = 1'b1;
    tick();
    chk("t4 done e22", model(6, 4, 22));
    tick();
    enable_timer = 1'b0;
    run("t4n", 15, 2, 0, 24);
    // asynchronous reset during RUN
    start(6, 4);
    run("t5", 6, 4, 0, 10);
    #2 n_rst = 1'b0;
    #1 chk("t5 async reset", 7'd0);
    #3 n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t5 idle %0d", i), 7'd0);
    end
    start(3, 2);
    run("t5s", 3, 2, 0, 6);
    // maximum widths
    start(15, 15);
    run("t6", 15, 15, 0, 220);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bit_timer.md
Name: bit_timer

Overview:
- Bit-period sequencer for the serial receive path; sits directly downstream of the flex counter.
- On a start request it times a packet of num_bits bit periods of clks_per_bit clocks each.
- It issues a one-cycle shift_strobe at the middle of each bit, then a one-cycle packet_done.
- Its strobes drive the shift register and its done pulse drives the receive control FSM.

Parameters:
CNT_BITS, 4, width of clks_per_bit and the internal cycle counter (maximum bit period 2**CNT_BITS-1)
BIT_CNT_BITS, 4, width of num_bits, bit_index and the internal bit counter

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  reset; asynchronous, active-low
enable_timer  input  1  start request, sampled only in IDLE
abort  input  1  synchronous cancel of the current packet
clks_per_bit  input  CNT_BITS  bit period P in clocks; latched at start
num_bits  input  BIT_CNT_BITS  bits per packet N; latched at start
shift_strobe  output  1  registered one-cycle pulse at mid-bit
bit_index  output  BIT_CNT_BITS  0-based index of the bit currently being strobed
busy  output  1  high while a packet is being timed
packet_done  output  1  registered one-cycle pulse after the last strobe

Behaviour:
- Reset (n_rst=0, asynchronous):
  - state=IDLE.
  - shift_strobe, packet_done and busy = 0; bit_index = 0; internal counters = 0.
  - Takes effect immediately, including in the middle of a packet.
- All outputs are registered. Timing below is given in rising-edge numbers, with the start-accept edge as edge 0.
- Latched values at start:
  - P = clks_per_bit, clamped to 2 if the input is 0 or 1.
  - N = num_bits, clamped to 1 if the input is 0.
  - H = P>>1.
  - Inputs changing after edge 0 have no effect until the next start.
- States:
  - IDLE -> HALF when enable_timer=1 and abort=0. busy goes to 1 at edge 0.
  - HALF: the cycle counter counts from 1. At edge H, shift_strobe=1 for one cycle with bit_index=0. The cycle counter reloads; the next state is RUN if N>1, otherwise DONE.
  - RUN: strobe k (k=1..N-1) rises at edge H+k*P, with bit_index=k during the strobe cycle. bit_index holds its value between strobes. After strobe N-1 the next state is DONE.
  - DONE: at edge H+(N-1)*P+1, packet_done=1 for one cycle and busy=0. bit_index returns to 0 and the next state is IDLE.
- Strobe count is exactly N per packet. Strobe spacing is exactly P clocks.
- The cycle counter is CNT_BITS wide and never wraps inside a bit, because P ≤ 2**CNT_BITS-1.
- enable_timer while busy=1, or in the packet_done cycle: ignored, not queued. A new start is accepted on the first edge after packet_done, so back-to-back packets have one idle cycle between them.
- abort (priority below reset, above everything else):
  - At the next edge: state=IDLE, busy=0, shift_strobe=0, bit_index=0. No packet_done is issued.
  - abort together with enable_timer in IDLE: stays IDLE.
  - abort in the same cycle DONE would fire: packet_done is suppressed.
- shift_strobe and packet_done are never high in the same cycle.

Test Plan:
1. P=10, N=8, start at edge 0 -> shift_strobe at edges 5,15,25,...,75 with bit_index 0..7; packet_done at edge 76; busy high for edges 0..75 and low at edge 76.
2. P=4, N=1 -> single strobe at edge 2 with bit_index=0; packet_done at edge 3. Then P=1, N=0 -> clamped to P=2, N=1: strobe at edge 1, done at edge 2.
3. P=10, N=8, abort asserted for the edge-20 sample -> busy=0 at edge 20; no strobes after edge 15; no packet_done. A restart at edge 22 then times a correct new packet.
4. P=6, N=4 running:
   - Drive clks_per_bit=15 and num_bits=2 mid-packet, and pulse enable_timer at edge 8 -> timing unchanged: strobes at 3,9,15,21 and done at 22.
   - enable_timer held high through the done cycle -> next packet accepted at edge 23.
5. Drop n_rst at a mid-cycle time during RUN -> all outputs 0 immediately, without waiting for a clock. After release, the block idles until enable_timer.
6. P=15, N=15 at the maximum widths -> 15 strobes spaced exactly 15 clocks apart starting at edge 7; bit_index reaches 14 with no wrap; packet_done at edge 218.
